// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//   CLA_WIDTH / CLA_BLOCK : default operand width and lookahead group size
//   cla_num_stg()         : pipeline depth (one lookahead group per stage)
//   cla_stage_t           : per-stage pipeline record at the default width
package cla_pkg;

  localparam int CLA_WIDTH = 16;
  localparam int CLA_BLOCK = 4;

  // One group of BLOCK bits is resolved per stage, so depth = WIDTH / BLOCK.
  // A zero block size is trapped by the elaboration check in the top; the
  // guard here only keeps the division itself well defined.
  function automatic int cla_num_stg(input int width, input int block);
    return (block > 0) ? (width / block) : 1;
  endfunction

  // Pipeline record: operands ride along (skewed) so later stages can
  // resolve their own group; sum bits fill in from the bottom up.
  typedef struct packed {
    logic                 valid;
    logic [CLA_WIDTH-1:0] a;
    logic [CLA_WIDTH-1:0] b_eff;
    logic [CLA_WIDTH-1:0] sum;
    logic                 carry;
    logic                 a_msb;
    logic                 b_msb;
  } cla_stage_t;

endpackage

// File: rtl/cla_group.sv
// Combinational BLOCK-bit carry-lookahead group.
//   a, b : group operand bits (b already inverted for subtraction)
//   ci   : carry into the group
//   s    : group sum bits
//   co   : carry out of the group, from group generate/propagate
module cla_group #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co
);

  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] c;
  logic             grp_g;
  logic             grp_p;

  assign g = a & b;
  assign p = a ^ b;

  // Every internal carry is a flat sum of products of g/p terms and ci,
  // so no carry depends on the previous one (true lookahead, not ripple):
  //   c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]ci
  always_comb begin
    logic acc;
    logic prod;
    c    = '0;
    acc  = 1'b0;
    prod = 1'b0;
    c[0] = ci;
    for (int i = 0; i < BLOCK - 1; i++) begin
      acc = ci;
      for (int k = 0; k <= i; k++) acc = acc & p[k];
      for (int j = 0; j <= i; j++) begin
        prod = g[j];
        for (int k = j + 1; k <= i; k++) prod = prod & p[k];
        acc = acc | prod;
      end
      c[i+1] = acc;
    end
  end

  // Group generate / propagate, independent of ci.
  always_comb begin
    logic gacc;
    logic gprod;
    gacc  = 1'b0;
    gprod = 1'b0;
    for (int j = 0; j < BLOCK; j++) begin
      gprod = g[j];
      for (int k = j + 1; k < BLOCK; k++) gprod = gprod & p[k];
      gacc = gacc | gprod;
    end
    grp_g = gacc;
    grp_p = &p;
  end

  assign s  = p ^ c;
  assign co = grp_g | (grp_p & ci);

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor, WIDTH bits, one BLOCK-bit
// lookahead group per stage, NUM_STG = WIDTH/BLOCK stages of latency.
//   clk, rst            : rising-edge clock, async active-high reset
//   in_valid / in_ready : operand beat handshake (a, b, cin, sub)
//   sub                 : 0 -> a+b+cin, 1 -> a-b as a+~b+1 (cin ignored)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
//   cout                : carry out of the MSB (in sub mode 1 = no borrow)
//   ovf                 : signed two's-complement overflow
//
// Handshake: a beat transfers on a rising edge where valid & ready are both
// 1. The pipeline moves as one unit: advance = ~out_valid | out_ready, and
// in_ready = advance. When advance is 0 every stage, the output stage
// included, holds, so a blocked result stays stable and nothing is lost.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int BLOCK = CLA_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NUM_STG = cla_num_stg(WIDTH, BLOCK);
  localparam int LAST    = NUM_STG - 1;

  if (BLOCK < 1 || BLOCK > 8 || WIDTH < BLOCK || (WIDTH % BLOCK) != 0) begin : g_param_check
    $error("cla_pipe_adder: WIDTH must be a multiple of BLOCK, BLOCK in 1..8");
  end

  // Same record as cla_stage_t, sized for this instance's WIDTH.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             a_msb;
    logic             b_msb;
  } stage_t;

  stage_t           stg_q [NUM_STG];
  stage_t           stg_d [NUM_STG];
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             advance;
  logic [BLOCK-1:0] grp_sum [NUM_STG];
  logic [NUM_STG-1:0] grp_co;

  // Subtraction is a + ~b + 1: invert b and force the carry-in.
  assign b_eff = sub ? ~b : b;
  assign c0    = sub | cin;

  // Group 0 works on the live inputs; group k works on the operands that
  // stage k-1 carried forward, with the carry stage k-1 registered.
  for (genvar k = 0; k < NUM_STG; k++) begin : g_grp
    if (k == 0) begin : g_first
      cla_group #(.BLOCK(BLOCK)) u_grp (
        .a  (a[BLOCK-1:0]),
        .b  (b_eff[BLOCK-1:0]),
        .ci (c0),
        .s  (grp_sum[k]),
        .co (grp_co[k])
      );
    end else begin : g_rest
      cla_group #(.BLOCK(BLOCK)) u_grp (
        .a  (stg_q[k-1].a[k*BLOCK +: BLOCK]),
        .b  (stg_q[k-1].b_eff[k*BLOCK +: BLOCK]),
        .ci (stg_q[k-1].carry),
        .s  (grp_sum[k]),
        .co (grp_co[k])
      );
    end
  end

  // Next-state for every stage. Bubbles are loaded too; their valid bit of
  // 0 is all that matters downstream.
  always_comb begin
    for (int k = 0; k < NUM_STG; k++) stg_d[k] = '0;
    stg_d[0].valid            = in_valid;
    stg_d[0].a                = a;
    stg_d[0].b_eff            = b_eff;
    stg_d[0].sum[BLOCK-1:0]   = grp_sum[0];
    stg_d[0].carry            = grp_co[0];
    stg_d[0].a_msb            = a[WIDTH-1];
    stg_d[0].b_msb            = b_eff[WIDTH-1];
    for (int k = 1; k < NUM_STG; k++) begin
      stg_d[k]                       = stg_q[k-1];
      stg_d[k].sum[k*BLOCK +: BLOCK] = grp_sum[k];
      stg_d[k].carry                 = grp_co[k];
    end
  end

  assign advance  = ~stg_q[LAST].valid | out_ready;
  assign in_ready = advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_STG; k++) stg_q[k] <= '0;
    end else if (advance) begin
      for (int k = 0; k < NUM_STG; k++) stg_q[k] <= stg_d[k];
    end
  end

  // The last stage register is the output register.
  assign out_valid = stg_q[LAST].valid;
  assign sum       = stg_q[LAST].sum;
  assign cout      = stg_q[LAST].carry;
  assign ovf       = (stg_q[LAST].a_msb == stg_q[LAST].b_msb) &
                     (stg_q[LAST].sum[WIDTH-1] != stg_q[LAST].a_msb);

endmodule

// File: tb/tb_cla_pipe_adder.sv
module tb_cla_pipe_adder;

  localparam int W   = 16;
  localparam int BL  = 4;
  localparam int NST = W / BL;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks   = 0;
  int failures = 0;

  // Scoreboard entries are {ovf, cout, sum}.
  logic [W+1:0] exp_q[$];
  logic [W+1:0] got_q[$];

  // Directed cases: a, b, cin, sub -> sum, cout, ovf
  logic [W-1:0] t_a   [6] = '{16'h0005, 16'hFFFF, 16'hAAAA, 16'h7FFF, 16'h0005, 16'h8000};
  logic [W-1:0] t_b   [6] = '{16'h0003, 16'h0001, 16'h5555, 16'h0001, 16'h0007, 16'h0001};
  logic         t_cin [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic         t_sub [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [W-1:0] t_sum [6] = '{16'h0008, 16'h0000, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
  logic         t_co  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic         t_ov  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  cla_pipe_adder #(.WIDTH(W), .BLOCK(BL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Plain integer arithmetic: unsigned total gives sum/cout, signed total
  // gives overflow as "true result out of 16-bit signed range".
  function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic cv, input logic sv);
    longint ut;
    longint st;
    logic [W-1:0] s;
    logic co;
    logic ov;
    if (sv) begin
      ut = longint'(av) - longint'(bv) + 65536;
      st = longint'($signed(av)) - longint'($signed(bv));
    end else begin
      ut = longint'(av) + longint'(bv) + longint'(cv);
      st = longint'($signed(av)) + longint'($signed(bv)) + longint'(cv);
    end
    s  = W'(ut % 65536);
    co = (ut >= 65536);
    ov = (st > 32767) || (st < -32768);
    return {ov, co, s};
  endfunction

  function automatic logic [W-1:0] pick_operand();
    int r;
    r = $urandom_range(0, 7);
    case (r)
      0:       return 16'hFFFF;
      1:       return 16'h7FFF;
      2:       return 16'h8000;
      3:       return 16'h0000;
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- driver / monitor ----------------
  // Called at a negedge after the inputs for the next rising edge are set:
  // records the handshakes that edge will perform, then moves to the next
  // negedge.
  task automatic clk_step();
    #1;
    if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    if (out_valid && out_ready) got_q.push_back({ovf, cout, sum});
    @(negedge clk);
  endtask

  task automatic clear_queues();
    exp_q.delete();
    got_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (sum !== 16'h0000) begin failures++; $display("FAIL reset_sum got=%h exp=0000", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
  endtask

  // Single beats with out_ready=1: the result must show up on the NUM_STG-th
  // rising edge counting the accepting edge, i.e. NUM_STG-1 further edges.
  task automatic test_directed();
    int waits;
    for (int i = 0; i < 6; i++) begin
      clear_queues();
      out_ready = 1'b1;
      in_valid = 1'b1; a = t_a[i]; b = t_b[i]; cin = t_cin[i]; sub = t_sub[i];
      clk_step();
      in_valid = 1'b0; a = W'($urandom); b = W'($urandom);
      waits = 0;
      while (!out_valid && waits < 20) begin
        clk_step();
        waits++;
      end
      #1;
      checks++; if (waits !== NST - 1) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, waits + 1, NST); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL dir%0d_valid got=%b exp=1", i, out_valid); end
      checks++; if (sum !== t_sum[i]) begin failures++; $display("FAIL dir%0d_sum got=%h exp=%h", i, sum, t_sum[i]); end
      checks++; if (cout !== t_co[i]) begin failures++; $display("FAIL dir%0d_cout got=%b exp=%b", i, cout, t_co[i]); end
      checks++; if (ovf !== t_ov[i]) begin failures++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, ovf, t_ov[i]); end
      clk_step();
    end
    clear_queues();
  endtask

  task automatic test_backpressure();
    int n_sent;
    int stall_left;
    bit stall_started;
    logic [W+1:0] held;
    clear_queues();
    n_sent = 0; stall_left = 0; stall_started = 0; held = '0;
    for (int cyc = 0; cyc < 80 && got_q.size() < 6; cyc++) begin
      in_valid = (n_sent < 6);
      a = 16'h0001 + W'(n_sent); b = 16'h0000; cin = 1'b0; sub = 1'b0;
      if (!stall_started && out_valid) begin
        stall_started = 1;
        stall_left = 5;
        held = {ovf, cout, sum};
      end
      out_ready = !(stall_left > 0);
      #1;
      if (stall_left > 0) begin
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_stalled cyc=%0d got=%b exp=0", cyc, in_ready); end
        checks++; if ({ovf, cout, sum} !== held || out_valid !== 1'b1) begin
          failures++; $display("FAIL bp_hold cyc=%0d got=%h/%b exp=%h/1", cyc, {ovf, cout, sum}, out_valid, held);
        end
        stall_left--;
      end
      if (in_valid && in_ready) n_sent++;
      clk_step();
    end
    in_valid = 1'b0;
    checks++; if (stall_started !== 1'b1) begin failures++; $display("FAIL bp_stall_seen got=0 exp=1"); end
    checks++; if (got_q.size() !== 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 6; i++) begin
      checks++;
      if (got_q[i][W-1:0] !== 16'h0001 + W'(i) || got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL bp_order idx=%0d got=%h exp_sum=%h", i, got_q[i], 16'h0001 + W'(i));
      end
    end
    clear_queues();
  endtask

  task automatic test_random();
    bit prev_stall;
    logic [W+1:0] prev_out;
    int drain;
    clear_queues();
    prev_stall = 0; prev_out = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = pick_operand();
      b         = pick_operand();
      cin       = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 4) < 3);
      #1;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || {ovf, cout, sum} !== prev_out) begin
          failures++; $display("FAIL rnd_stable cyc=%0d got=%h/%b exp=%h/1", cyc, {ovf, cout, sum}, out_valid, prev_out);
        end
      end
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, (!out_valid || out_ready));
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {ovf, cout, sum};
      clk_step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain = 0;
    while (got_q.size() < exp_q.size() && drain < 40) begin
      clk_step();
      drain++;
    end
    checks++; if (exp_q.size() == 0 || got_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL rnd_result idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    clear_queues();
  endtask

  task automatic test_reset_midflight();
    int seen;
    int waits;
    clear_queues();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 16'h1234 + W'(i); b = 16'h0101; cin = 1'b0; sub = 1'b0;
      clk_step();
    end
    in_valid = 1'b0;
    clk_step();
    #1;
    checks++; if (out_valid !== 1'b1 || sum !== 16'h1335) begin
      failures++; $display("FAIL mid_pre_reset got=%b/%h exp=1/1335", out_valid, sum);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
    checks++; if (sum !== 16'h0000) begin failures++; $display("FAIL mid_rst_sum got=%h exp=0000", sum); end
    checks++; if (cout !== 1'b0 || ovf !== 1'b0) begin failures++; $display("FAIL mid_rst_flags got=%b%b exp=00", cout, ovf); end
    @(negedge clk);
    rst = 1'b0;
    clear_queues();
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      clk_step();
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL mid_stale got=%0d exp=0", seen); end
    in_valid = 1'b1; a = 16'h0100; b = 16'h0023; cin = 1'b1; sub = 1'b0;
    clk_step();
    in_valid = 1'b0;
    waits = 0;
    while (!out_valid && waits < 20) begin
      clk_step();
      waits++;
    end
    #1;
    checks++; if (waits !== NST - 1) begin failures++; $display("FAIL mid_latency got=%0d exp=%0d", waits + 1, NST); end
    checks++; if (sum !== 16'h0124) begin failures++; $display("FAIL mid_sum got=%h exp=0124", sum); end
    clk_step();
    clear_queues();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
